// File: rtl/mem_ctrl_pipelined.sv
// Pipelined single-port on-chip memory controller: clears its array after reset, then serves
// read/write requests with in-order, backpressurable read responses. Optional parity: MEM_CTRL_PARITY_EN.
module mem_ctrl_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 256,
  parameter int RD_LATENCY     = 2,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    rd_wr_mem,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    parity_inject,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rsp_err,
  output logic                    init_done
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(RSP_FIFO_DEPTH + RD_LATENCY + 1) + 1;
  localparam int LS = RD_LATENCY - 1;

  typedef enum logic {INIT, RUN} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [FW-1:0] wptr_q, rptr_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [RSP_FIFO_DEPTH];
  logic                  fifo_err_q  [RSP_FIFO_DEPTH];

  logic                  stg_vld_q  [RD_LATENCY];
  logic                  stg_oor_q  [RD_LATENCY];
  logic [DATA_WIDTH-1:0] stg_data_q [RD_LATENCY];

  logic [IW-1:0]         idx;
  logic                  addr_oor, credit_ok, accept, rd_acc, wr_acc, init_wr;
  logic                  push, pop, par_err, push_err;
  logic [DATA_WIDTH-1:0] push_data;

  assign idx       = mem_addr[IW-1:0];
  assign addr_oor  = ({1'b0, mem_addr} >= (ADDR_WIDTH+1)'(DEPTH));
  // Reads still travelling through the pipeline hold a FIFO slot, so the FIFO can never overflow.
  assign credit_ok = (in_flight_q + fifo_cnt_q) < CW'(RSP_FIFO_DEPTH);
  assign accept    = req_valid && req_ready;
  assign rd_acc    = accept && !rd_wr_mem;
  assign wr_acc    = accept && rd_wr_mem && !addr_oor;
  assign init_wr   = rst_n && (state_q == INIT);
  assign init_done = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    req_ready  = 1'b0;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IW'(DEPTH - 1)) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end
      end
      RUN:     req_ready = credit_ok;
      default: state_d = INIT;
    endcase
  end

`ifdef MEM_CTRL_PARITY_EN
  logic                  par_q [DEPTH];
  logic                  stg_par_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] wr_merged;

  for (genvar gi = 0; gi < NB; gi++) begin : g_merge
    assign wr_merged[gi*8 +: 8] = wr_be[gi] ? wr_data[gi*8 +: 8] : mem_q[idx][gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem_q[init_cnt_q] <= '0;
      par_q[init_cnt_q] <= 1'b0;
    end else if (wr_acc) begin
      mem_q[idx] <= wr_merged;
      par_q[idx] <= (^wr_merged) ^ parity_inject;
    end
  end

  assign par_err = ^{stg_data_q[LS], stg_par_q[LS]};
`else
  logic unused_parity_inject;
  assign unused_parity_inject = parity_inject;

  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem_q[init_cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem_q[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign par_err = 1'b0;
`endif

  // Stage 0 is the registered RAM read; later stages only add latency.
  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stg
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!rst_n) stg_vld_q[gi] <= 1'b0;
        else        stg_vld_q[gi] <= rd_acc;
      end
      always_ff @(posedge clk) begin
        if (rd_acc) begin
          stg_data_q[gi] <= mem_q[idx];
          stg_oor_q[gi]  <= addr_oor;
`ifdef MEM_CTRL_PARITY_EN
          stg_par_q[gi]  <= par_q[idx];
`endif
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (!rst_n) stg_vld_q[gi] <= 1'b0;
        else        stg_vld_q[gi] <= stg_vld_q[gi-1];
      end
      always_ff @(posedge clk) begin
        stg_data_q[gi] <= stg_data_q[gi-1];
        stg_oor_q[gi]  <= stg_oor_q[gi-1];
`ifdef MEM_CTRL_PARITY_EN
        stg_par_q[gi]  <= stg_par_q[gi-1];
`endif
      end
    end
  end

  assign push      = stg_vld_q[LS];
  assign push_data = stg_oor_q[LS] ? '0 : stg_data_q[LS];
  assign push_err  = stg_oor_q[LS] | par_err;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    in_flight_d = in_flight_q + CW'(rd_acc) - CW'(push);
    fifo_cnt_d  = fifo_cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_flight_q <= '0;
      fifo_cnt_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      if (push) wptr_q <= (wptr_q == FW'(RSP_FIFO_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == FW'(RSP_FIFO_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wptr_q] <= push_data;
      fifo_err_q[wptr_q]  <= push_err;
    end
  end

  assign rsp_valid = (fifo_cnt_q != '0);
  assign rd_data   = rsp_valid ? fifo_data_q[rptr_q] : '0;
  assign rsp_err   = rsp_valid && fifo_err_q[rptr_q];

endmodule

// File: tb/tb_mem_ctrl_pipelined.sv
// Directed self-checking bench for mem_ctrl_pipelined (default parameters).
module tb_mem_ctrl_pipelined;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int DEPTH = 256;
  localparam int LAT = 2;
  localparam int FDEPTH = 4;
`ifdef MEM_CTRL_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, req_valid, req_ready, rd_wr_mem, parity_inject;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [3:0]    wr_be;
  logic          rsp_valid, rsp_ready, rsp_err, init_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [DW-1:0] rq_data[$];
  logic          rq_err[$];
  int            rq_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rq_data.push_back(rd_data);
      rq_err.push_back(rsp_err);
      rq_cyc.push_back(cyc);
    end
  end

  mem_ctrl_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                       .RD_LATENCY(LAT), .RSP_FIFO_DEPTH(FDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .rd_wr_mem(rd_wr_mem), .mem_addr(mem_addr), .wr_data(wr_data), .wr_be(wr_be),
    .parity_inject(parity_inject), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rd_data(rd_data), .rsp_err(rsp_err), .init_done(init_done)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_rsp();
    rq_data.delete(); rq_err.delete(); rq_cyc.delete();
  endtask

  task automatic issue(input logic wr, input int a, input logic [DW-1:0] d,
                       input logic [3:0] be, input logic inj);
    logic done = 1'b0;
    req_valid = 1'b1; rd_wr_mem = wr; mem_addr = AW'(a);
    wr_data = d; wr_be = be; parity_inject = inj;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk); done = req_ready;
      tick();
    end
    if (done) acc_cyc = cyc;
    else begin
      checks++; errors++;
      $display("FAIL issue_timeout addr=%0d req_ready never high within 100 cycles", a);
    end
    req_valid = 1'b0; parity_inject = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k = 0;
    while (rq_data.size() < n && k < 300) begin
      @(posedge clk); k++;
    end
    #1;
    checks++;
    if (rq_data.size() < n) begin
      errors++;
      $display("FAIL %s_rsp_count got=%0d expected=%0d", tag, rq_data.size(), n);
    end
  endtask

  // Releases reset and checks INIT ends after exactly DEPTH edges.
  task automatic run_init(input string tag);
    int bad = 0;
    rst_n = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      tick();
      if (init_done !== 1'b0 || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_init_early got %0d early cycles expected 0", tag, bad);
    end
    tick();
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_init_done got init_done=%b req_ready=%b expected 1 1", tag, init_done, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rd_wr_mem = 1'b0; mem_addr = '0;
    wr_data = '0; wr_be = '0; parity_inject = 1'b0; rsp_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_err, init_done} !== 4'b0000 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b vld=%b err=%b done=%b data=%h expected all 0",
               req_ready, rsp_valid, rsp_err, init_done, rd_data);
    end
    run_init("reset");
    clear_rsp();
    issue(1'b0, 'h10, '0, 4'h0, 1'b0);
    wait_rsp(1, "reset_read");
    checks++;
    if (rq_data[0] !== 32'h0 || rq_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_read10 got data=%h err=%b expected 00000000 0", rq_data[0], rq_err[0]);
    end
    checks++;
    if (rq_cyc[0] - acc_cyc !== LAT) begin
      errors++;
      $display("FAIL reset_read_latency got %0d expected %0d", rq_cyc[0] - acc_cyc, LAT);
    end
  endtask

  task automatic test_byte_enable();
    clear_rsp();
    issue(1'b1, 'h05, 32'hDEADBEEF, 4'b0101, 1'b0);
    issue(1'b0, 'h05, '0, 4'h0, 1'b0);
    issue(1'b1, 'h05, 32'hFFFFFFFF, 4'b0000, 1'b0);
    issue(1'b0, 'h05, '0, 4'h0, 1'b0);
    wait_rsp(2, "be");
    checks++;
    if (rq_data[0] !== 32'h00AD00EF || rq_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL be_merge got data=%h err=%b expected 00ad00ef 0", rq_data[0], rq_err[0]);
    end
    checks++;
    if (rq_data[1] !== 32'h00AD00EF) begin
      errors++;
      $display("FAIL be_zero_noop got data=%h expected 00ad00ef", rq_data[1]);
    end
  endtask

  task automatic test_back_to_back();
    int first_acc;
    for (int i = 0; i < 8; i++) issue(1'b1, i, 32'h1000 + i, 4'hF, 1'b0);
    clear_rsp();
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, i, '0, 4'h0, 1'b0);
      if (i == 0) first_acc = acc_cyc;
    end
    wait_rsp(8, "b2b");
    checks++;
    if (rq_cyc[0] - first_acc !== LAT) begin
      errors++;
      $display("FAIL b2b_latency got %0d expected %0d", rq_cyc[0] - first_acc, LAT);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rq_data[i] !== 32'h1000 + i || rq_cyc[i] - rq_cyc[0] !== i) begin
        errors++;
        $display("FAIL b2b_rsp%0d got data=%h offset=%0d expected %h offset=%0d",
                 i, rq_data[i], rq_cyc[i] - rq_cyc[0], 32'h1000 + i, i);
      end
    end
  endtask

  task automatic test_backpressure();
    int   n_acc = 0;
    logic acc;
    clear_rsp();
    rsp_ready = 1'b0; req_valid = 1'b1; rd_wr_mem = 1'b0; mem_addr = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); acc = req_ready;
      tick();
      if (acc) begin
        n_acc++;
        mem_addr = AW'(n_acc);
      end
    end
    checks++;
    if (n_acc !== FDEPTH || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_credits got accepted=%0d req_ready=%b expected %0d 0", n_acc, req_ready, FDEPTH);
    end
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rd_data !== 32'h1000 || rq_data.size() != 0) begin
      errors++;
      $display("FAIL bp_hold got vld=%b data=%h popped=%0d expected 1 00001000 0",
               rsp_valid, rd_data, rq_data.size());
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_return got req_ready=%b expected 1", req_ready);
    end
    for (int i = 4; i < 8; i++) issue(1'b0, i, '0, 4'h0, 1'b0);
    wait_rsp(8, "bp");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rq_data[i] !== 32'h1000 + i) begin
        errors++;
        $display("FAIL bp_order%0d got data=%h expected %h", i, rq_data[i], 32'h1000 + i);
      end
    end
  endtask

  task automatic test_out_of_range();
    clear_rsp();
    issue(1'b0, 300, '0, 4'h0, 1'b0);
    issue(1'b1, 300, 32'hCAFEF00D, 4'hF, 1'b0);
    issue(1'b0, 300 % DEPTH, '0, 4'h0, 1'b0);
    wait_rsp(2, "oor");
    checks++;
    if (rq_data[0] !== 32'h0 || rq_err[0] !== 1'b1) begin
      errors++;
      $display("FAIL oor_read got data=%h err=%b expected 00000000 1", rq_data[0], rq_err[0]);
    end
    checks++;
    if (rq_data[1] !== 32'h0 || rq_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL oor_write_dropped got data=%h err=%b expected 00000000 0", rq_data[1], rq_err[1]);
    end
  endtask

  task automatic test_parity();
    clear_rsp();
    issue(1'b1, 'h20, 32'h1, 4'hF, 1'b1);
    issue(1'b1, 'h21, 32'h1, 4'hF, 1'b0);
    issue(1'b0, 'h20, '0, 4'h0, 1'b0);
    issue(1'b0, 'h21, '0, 4'h0, 1'b0);
    wait_rsp(2, "par");
    checks++;
    if (rq_data[0] !== 32'h1 || rq_err[0] !== PAR_EN) begin
      errors++;
      $display("FAIL par_inject got data=%h err=%b expected 00000001 %b", rq_data[0], rq_err[0], PAR_EN);
    end
    checks++;
    if (rq_data[1] !== 32'h1 || rq_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL par_clean got data=%h err=%b expected 00000001 0", rq_data[1], rq_err[1]);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, i, '0, 4'h0, 1'b0);
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill got rsp_valid=%b expected 1", rsp_valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL mid_reset got vld=%b rdy=%b done=%b data=%h expected 0 0 0 0",
               rsp_valid, req_ready, init_done, rd_data);
    end
    run_init("mid");
    rsp_ready = 1'b1;
    clear_rsp();
    issue(1'b0, 'h05, '0, 4'h0, 1'b0);
    issue(1'b0, 'h03, '0, 4'h0, 1'b0);
    wait_rsp(2, "mid");
    checks++;
    if (rq_data[0] !== 32'h0 || rq_data[1] !== 32'h0) begin
      errors++;
      $display("FAIL mid_cleared got %h %h expected 00000000 00000000", rq_data[0], rq_data[1]);
    end
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_parity();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
